// File: rtl/matmul_pkg.sv
// Shared constants, register map and FSM state type for the matmul APB front-end.
// Optional build macro used by the top: MATMUL_APB_PSLVERR_EN (enables pslverr reporting).
package matmul_pkg;

    localparam int unsigned DATA_WIDTH  = 8;
    localparam int unsigned BUS_WIDTH   = 32;
    localparam int unsigned ADDR_WIDTH  = 16;
    localparam int unsigned MAX_DIM     = BUS_WIDTH / DATA_WIDTH;
    localparam int unsigned SP_NTARGETS = 4;

    localparam int unsigned ROW_W     = $clog2(MAX_DIM);
    localparam int unsigned TGT_W     = $clog2(SP_NTARGETS);
    localparam int unsigned SP_ADDR_W = TGT_W + ROW_W;

    // Region select lives in paddr[4:0]; row and SP target sit above it.
    localparam int unsigned REGION_W = 5;
    localparam int unsigned ROW_LSB  = 5;
    localparam int unsigned TGT_LSB  = ROW_LSB + ROW_W;

    localparam logic [REGION_W-1:0] REG_CONTROL   = 5'h00;
    localparam logic [REGION_W-1:0] REG_OPERAND_A = 5'h04;
    localparam logic [REGION_W-1:0] REG_OPERAND_B = 5'h08;
    localparam logic [REGION_W-1:0] REG_FLAGS     = 5'h0C;
    localparam logic [REGION_W-1:0] REG_SP        = 5'h10;

    // CONTROL bit fields.
    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_MODE_BIAS = 1;
    localparam int unsigned CTRL_WT_LSB    = 2;
    localparam int unsigned CTRL_RT_LSB    = 4;
    localparam int unsigned CTRL_N_LSB     = 8;
    localparam int unsigned CTRL_K_LSB     = 10;
    localparam int unsigned CTRL_M_LSB     = 12;

    // Bits kept by the CONTROL register; START is a pulse and is never stored.
    function automatic logic [BUS_WIDTH-1:0] ctrl_rw_mask();
        logic [BUS_WIDTH-1:0] m;
        m = '0;
        m[CTRL_MODE_BIAS]        = 1'b1;
        m[CTRL_WT_LSB +: 2]      = 2'b11;
        m[CTRL_RT_LSB +: 2]      = 2'b11;
        m[CTRL_N_LSB +: 2]       = 2'b11;
        m[CTRL_K_LSB +: 2]       = 2'b11;
        m[CTRL_M_LSB +: 2]       = 2'b11;
        return m;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_SP_WAIT = 2'd2
    } apb_state_e;

endpackage

// File: rtl/matmul_operand_rf.sv
// MAX_DIM x BUS_WIDTH operand register file; each row element has its own write strobe.
module matmul_operand_rf
    import matmul_pkg::*;
(
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           we_i,
    input  logic [ROW_W-1:0]               row_i,
    input  logic [MAX_DIM-1:0]             strb_i,
    input  logic [BUS_WIDTH-1:0]           wdata_i,
    output logic [MAX_DIM*BUS_WIDTH-1:0]   rows_o
);

    logic [MAX_DIM-1:0][BUS_WIDTH-1:0] rows_d, rows_q;

    // Merge strobed elements of the write data into the addressed row.
    always_comb begin
        rows_d = rows_q;
        if (we_i) begin
            for (int e = 0; e < MAX_DIM; e++) begin
                if (strb_i[e]) begin
                    rows_d[row_i][e*DATA_WIDTH +: DATA_WIDTH] = wdata_i[e*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Row storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rows_q <= '0;
        end else begin
            rows_q <= rows_d;
        end
    end

    assign rows_o = rows_q;

endmodule

// File: rtl/matmul_apb_slave.sv
// APB3 slave front-end of the matmul accelerator: register map decode, CONTROL and
// operand storage, flag readback and one-wait-state scratchpad reads.
// Build macro: MATMUL_APB_PSLVERR_EN -- when defined, illegal accesses raise pslverr_o;
// otherwise pslverr_o is 0 and illegal accesses are silently dropped.
module matmul_apb_slave
    import matmul_pkg::*;
(
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           psel_i,
    input  logic                           penable_i,
    input  logic                           pwrite_i,
    input  logic [MAX_DIM-1:0]             pstrb_i,
    input  logic [ADDR_WIDTH-1:0]          paddr_i,
    input  logic [BUS_WIDTH-1:0]           pwdata_i,
    output logic [BUS_WIDTH-1:0]           prdata_o,
    output logic                           pready_o,
    output logic                           pslverr_o,
    output logic                           busy_o,
    output logic                           start_o,
    output logic [BUS_WIDTH-1:0]           ctrl_o,
    output logic [MAX_DIM*BUS_WIDTH-1:0]   a_rows_o,
    output logic [MAX_DIM*BUS_WIDTH-1:0]   b_rows_o,
    input  logic                           busy_core_i,
    input  logic [BUS_WIDTH-1:0]           flags_i,
    output logic                           sp_rd_en_o,
    output logic [SP_ADDR_W-1:0]           sp_rd_addr_o,
    input  logic [BUS_WIDTH-1:0]           sp_rd_data_i
);

    apb_state_e state_d, state_q;
    logic [BUS_WIDTH-1:0] ctrl_d, ctrl_q;
    logic                 start_d, start_q;

    logic [REGION_W-1:0] region;
    logic [ROW_W-1:0]    row;
    logic [TGT_W-1:0]    tgt;
    logic                is_ctrl, is_a, is_b, is_flags, is_sp, is_illegal;
    logic                acc_err;
    logic                wr_commit;
    logic                pslverr_raw;
    logic [BUS_WIDTH-1:0] rd_mux;

    logic [MAX_DIM-1:0][BUS_WIDTH-1:0] a_rows, b_rows;

    // Address bits above the SP target field are not decoded.
    logic unused_paddr;
    assign unused_paddr = ^paddr_i[ADDR_WIDTH-1:TGT_LSB+TGT_W];

    assign region = paddr_i[REGION_W-1:0];
    assign row    = paddr_i[ROW_LSB +: ROW_W];
    assign tgt    = paddr_i[TGT_LSB +: TGT_W];

    assign is_ctrl    = (region == REG_CONTROL);
    assign is_a       = (region == REG_OPERAND_A);
    assign is_b       = (region == REG_OPERAND_B);
    assign is_flags   = (region == REG_FLAGS);
    assign is_sp      = (region == REG_SP);
    assign is_illegal = !(is_ctrl || is_a || is_b || is_flags || is_sp);

    assign busy_o = busy_core_i | start_q;

    // Illegal accesses: unknown region, writes to read-only regions, writes while busy.
    // The same condition blocks the commit in both builds; only reporting differs.
    assign acc_err = is_illegal
                   | (pwrite_i & (is_flags | is_sp))
                   | (pwrite_i & busy_o);

    // Read data for zero-wait regions; unknown regions read as 0.
    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            is_ctrl:  rd_mux = ctrl_q;
            is_a:     rd_mux = a_rows[row];
            is_b:     rd_mux = b_rows[row];
            is_flags: rd_mux = flags_i;
            default:  rd_mux = '0;
        endcase
    end

    // APB transfer FSM and response outputs.
    always_comb begin
        state_d      = state_q;
        pready_o     = 1'b0;
        pslverr_raw  = 1'b0;
        prdata_o     = '0;
        sp_rd_en_o   = 1'b0;
        sp_rd_addr_o = '0;
        wr_commit    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // penable without a setup phase is ignored here.
                if (psel_i && !penable_i) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (!psel_i) begin
                    state_d = ST_IDLE;
                end else if (!penable_i) begin
                    // Repeated setup phase: keep waiting for the access phase.
                    state_d = ST_ACCESS;
                end else if (is_sp && !pwrite_i) begin
                    sp_rd_en_o   = 1'b1;
                    sp_rd_addr_o = {tgt, row};
                    state_d      = ST_SP_WAIT;
                end else begin
                    pready_o    = 1'b1;
                    pslverr_raw = acc_err;
                    state_d     = ST_IDLE;
                    if (pwrite_i) begin
                        wr_commit = !acc_err;
                    end else if (!acc_err) begin
                        prdata_o = rd_mux;
                    end
                end
            end
            ST_SP_WAIT: begin
                state_d = ST_IDLE;
                if (psel_i && penable_i) begin
                    pready_o = 1'b1;
                    prdata_o = sp_rd_data_i;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef MATMUL_APB_PSLVERR_EN
    assign pslverr_o = pslverr_raw;
`else
    assign pslverr_o = 1'b0;
    logic unused_pslverr;
    assign unused_pslverr = pslverr_raw;
`endif

    // CONTROL update and start pulse generation.
    always_comb begin
        ctrl_d  = ctrl_q;
        start_d = 1'b0;
        if (wr_commit && is_ctrl) begin
            ctrl_d  = pwdata_i & ctrl_rw_mask();
            start_d = pwdata_i[CTRL_START_BIT];
        end
    end

    // State, CONTROL and start registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ctrl_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            start_q <= start_d;
        end
    end

    assign start_o = start_q;
    assign ctrl_o  = ctrl_q;

    matmul_operand_rf u_rf_a (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (wr_commit & is_a),
        .row_i   (row),
        .strb_i  (pstrb_i),
        .wdata_i (pwdata_i),
        .rows_o  (a_rows)
    );

    matmul_operand_rf u_rf_b (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (wr_commit & is_b),
        .row_i   (row),
        .strb_i  (pstrb_i),
        .wdata_i (pwdata_i),
        .rows_o  (b_rows)
    );

    assign a_rows_o = a_rows;
    assign b_rows_o = b_rows;

endmodule

// File: tb/tb_matmul_apb_slave.sv
// Directed self-checking bench for matmul_apb_slave.
module tb_matmul_apb_slave;

`ifdef MATMUL_APB_PSLVERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         psel, penable, pwrite;
    logic [3:0]   pstrb;
    logic [15:0]  paddr;
    logic [31:0]  pwdata;
    logic [31:0]  prdata;
    logic         pready, pslverr, busy, start;
    logic [31:0]  ctrl;
    logic [127:0] a_rows, b_rows;
    logic         busy_core;
    logic [31:0]  flags;
    logic         sp_rd_en;
    logic [3:0]   sp_rd_addr;
    logic [31:0]  sp_rd_data;

    int checks = 0;
    int errors = 0;

    logic        rdy, err;
    logic [31:0] rd;

    matmul_apb_slave dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .psel_i       (psel),
        .penable_i    (penable),
        .pwrite_i     (pwrite),
        .pstrb_i      (pstrb),
        .paddr_i      (paddr),
        .pwdata_i     (pwdata),
        .prdata_o     (prdata),
        .pready_o     (pready),
        .pslverr_o    (pslverr),
        .busy_o       (busy),
        .start_o      (start),
        .ctrl_o       (ctrl),
        .a_rows_o     (a_rows),
        .b_rows_o     (b_rows),
        .busy_core_i  (busy_core),
        .flags_i      (flags),
        .sp_rd_en_o   (sp_rd_en),
        .sp_rd_addr_o (sp_rd_addr),
        .sp_rd_data_i (sp_rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Zero-wait transfer; samples the response in the first access cycle.
    task automatic apb(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                       input logic [3:0] strb, output logic o_rdy, output logic o_err,
                       output logic [31:0] o_rd);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        o_rdy = pready; o_err = pslverr; o_rd = prdata;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        rst = 1'b1; psel = 0; penable = 0; pwrite = 0; pstrb = 0; paddr = 0; pwdata = 0;
        busy_core = 0; flags = 32'h0000_0005; sp_rd_data = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_pready", {31'b0, pready}, 32'd0);
        check("rst_pslverr", {31'b0, pslverr}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_start_busy", {30'b0, start, busy}, 32'd0);
        check("rst_ctrl", ctrl, 32'd0);
        check("rst_a_rows", a_rows[31:0] | a_rows[63:32] | a_rows[95:64] | a_rows[127:96], 32'd0);
        check("rst_sp_en", {31'b0, sp_rd_en}, 32'd0);
        rst = 1'b0;

        // Operand A row 2: full write, then partial strobe write, then read
        apb(1'b1, 16'h0044, 32'h0403_0201, 4'b1111, rdy, err, rd);
        check("a_wr_full_rdy", {31'b0, rdy}, 32'd1);
        check("a_wr_full_err", {31'b0, err}, 32'd0);
        check("a_row2_full", a_rows[64 +: 32], 32'h0403_0201);
        apb(1'b1, 16'h0044, 32'hFFFF_FFFF, 4'b0101, rdy, err, rd);
        apb(1'b0, 16'h0044, 32'h0, 4'b0000, rdy, err, rd);
        check("a_rd_rdy", {31'b0, rdy}, 32'd1);
        check("a_rd_strb", rd, 32'h04FF_02FF);

        // Operand B row 0
        apb(1'b1, 16'h0008, 32'h1122_3344, 4'b1111, rdy, err, rd);
        apb(1'b0, 16'h0008, 32'h0, 4'b0000, rdy, err, rd);
        check("b_rd", rd, 32'h1122_3344);

        // Protocol violation: penable with no setup phase, A row 3
        @(posedge clk); #1;
        psel = 1; penable = 1; pwrite = 1; paddr = 16'h0064; pwdata = 32'h99; pstrb = 4'hF;
        @(negedge clk);
        check("noset_pready", {31'b0, pready}, 32'd0);
        @(posedge clk); #1;
        psel = 0; penable = 0; pwrite = 0;
        check("noset_a_row3", a_rows[96 +: 32], 32'd0);

        // CONTROL write with START
        apb(1'b1, 16'h0000, 32'h0000_3F01, 4'b0000, rdy, err, rd);
        check("ctrl_wr_err", {31'b0, err}, 32'd0);
        check("start_pulse", {30'b0, start, busy}, 32'd3);
        @(posedge clk); #1;
        check("start_clear", {31'b0, start}, 32'd0);
        apb(1'b0, 16'h0000, 32'h0, 4'b0000, rdy, err, rd);
        check("ctrl_rd", rd, 32'h0000_3F00);
        check("ctrl_o", ctrl, 32'h0000_3F00);

        // Writes while the core is busy
        busy_core = 1'b1;
        apb(1'b1, 16'h0008, 32'hAAAA_AAAA, 4'b1111, rdy, err, rd);
        check("busy_b_err", {31'b0, err}, {31'b0, ERR_EN});
        apb(1'b1, 16'h0000, 32'h0000_0001, 4'b0000, rdy, err, rd);
        check("busy_ctrl_err", {31'b0, err}, {31'b0, ERR_EN});
        check("busy_no_start", {31'b0, start}, 32'd0);
        busy_core = 1'b0;
        apb(1'b0, 16'h0008, 32'h0, 4'b0000, rdy, err, rd);
        check("busy_b_hold", rd, 32'h1122_3344);
        check("busy_ctrl_hold", ctrl, 32'h0000_3F00);

        // SP read target 1 row 3 -> paddr 0x10 | 3<<5 | 1<<7 = 0xF0
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = 0; paddr = 16'h00F0;
        @(posedge clk); #1;
        penable = 1;
        @(negedge clk);
        check("sp_en", {31'b0, sp_rd_en}, 32'd1);
        check("sp_addr", {28'b0, sp_rd_addr}, 32'h7);
        check("sp_wait_pready", {31'b0, pready}, 32'd0);
        @(negedge clk);
        check("sp_pready", {31'b0, pready}, 32'd1);
        check("sp_data", prdata, 32'hDEAD_BEEF);
        check("sp_en_low", {31'b0, sp_rd_en}, 32'd0);
        @(posedge clk); #1;
        psel = 0; penable = 0;
        @(negedge clk);
        check("idle_prdata", prdata, 32'd0);

        // FLAGS read, read-only and illegal regions
        apb(1'b0, 16'h000C, 32'h0, 4'b0000, rdy, err, rd);
        check("flags_rd", rd, 32'h0000_0005);
        apb(1'b1, 16'h000C, 32'h1234_5678, 4'b1111, rdy, err, rd);
        check("flags_wr_err", {31'b0, err}, {31'b0, ERR_EN});
        check("flags_wr_rdy", {31'b0, rdy}, 32'd1);
        apb(1'b1, 16'h0010, 32'h1234_5678, 4'b1111, rdy, err, rd);
        check("sp_wr_err", {31'b0, err}, {31'b0, ERR_EN});
        apb(1'b0, 16'h0014, 32'h0, 4'b0000, rdy, err, rd);
        check("ill_rd_err", {31'b0, err}, {31'b0, ERR_EN});
        check("ill_rd_data", rd, 32'd0);
        apb(1'b1, 16'h0054, 32'hFFFF_FFFF, 4'b1111, rdy, err, rd);
        check("ill_wr_err", {31'b0, err}, {31'b0, ERR_EN});
        check("ill_a_row2", a_rows[64 +: 32], 32'h04FF_02FF);
        check("ill_b_row0", b_rows[0 +: 32], 32'h1122_3344);
        check("ill_ctrl", ctrl, 32'h0000_3F00);

        // Reset during SP_WAIT
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = 0; paddr = 16'h00F0;
        @(posedge clk); #1;
        penable = 1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_out", {29'b0, pready, sp_rd_en, start}, 32'd0);
        check("mid_rst_prdata", prdata, 32'd0);
        check("mid_rst_ctrl", ctrl, 32'd0);
        check("mid_rst_a_row2", a_rows[64 +: 32], 32'd0);
        @(negedge clk);
        rst = 1'b0; psel = 0; penable = 0;
        apb(1'b1, 16'h0024, 32'hCAFE_F00D, 4'b1111, rdy, err, rd);
        check("post_rst_wr_rdy", {31'b0, rdy}, 32'd1);
        apb(1'b0, 16'h0024, 32'h0, 4'b0000, rdy, err, rd);
        check("post_rst_rd", rd, 32'hCAFE_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matmul_apb_slave.md
# matmul_apb_slave

APB3 slave front-end of the matmul accelerator: decodes the five-region register map, stores the control word and operand matrices A/B, exposes the core's flags, and serves scratchpad (SP) result reads to the bus. It sits between the APB master (golden bench / host) and the systolic core plus SP. It produces every `pready_o` / `pslverr_o` / `prdata_o` response the golden checker consumes.

## Interface
- `DATA_WIDTH`, 8: operand element width.
- `BUS_WIDTH`, 32: APB data width. `MAX_DIM = BUS_WIDTH/DATA_WIDTH` (4) elements per row.
- `ADDR_WIDTH`, 16: APB address width.
- `SP_NTARGETS`, 4: number of SP result matrices.
- `clk_i`  in  1  clock; all logic on its rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `psel_i`, `penable_i`, `pwrite_i`  in  1 each  APB controls.
- `pstrb_i`  in  MAX_DIM  per-element write enable.
- `paddr_i`  in  ADDR_WIDTH  address.
- `pwdata_i`  in  BUS_WIDTH  write data.
- `prdata_o`  out  BUS_WIDTH  read data.
- `pready_o`, `pslverr_o`  out  1 each  APB response.
- `busy_o`  out  1  `busy_core_i | start_o`.
- `start_o`  out  1  one-cycle compute start pulse.
- `ctrl_o`  out  BUS_WIDTH  control register.
- `a_rows_o`, `b_rows_o`  out  MAX_DIM*BUS_WIDTH  operand row arrays; row r at bits [r*BUS_WIDTH +: BUS_WIDTH].
- `busy_core_i`  in  1  core computing.
- `flags_i`  in  BUS_WIDTH  core overflow flags.
- `sp_rd_en_o`  out  1  SP read strobe.
- `sp_rd_addr_o`  out  log2(SP_NTARGETS)+log2(MAX_DIM)  {target, row}.
- `sp_rd_data_i`  in  BUS_WIDTH  SP data, valid one cycle after `sp_rd_en_o`.

## Operation
- Address decode:
  - Region is `paddr_i[4:0]`: CONTROL 0x00, OPERAND_A 0x04, OPERAND_B 0x08, FLAGS 0x0C, SP 0x10.
  - Row is `paddr_i[5 +: log2(MAX_DIM)]`.
  - SP target is the next `log2(SP_NTARGETS)` bits above row.
  - Any other region value is illegal.
- CONTROL fields:
  - [0] START: writing 1 pulses `start_o`. The bit is self-clearing and reads 0.
  - [1] MODE_BIAS.
  - [3:2] WRITE_TARGET.
  - [5:4] READ_TARGET.
  - [9:8] N-1, [11:10] K-1, [13:12] M-1.
  - Other bits read 0.
- OPERAND writes: only elements with `pstrb_i[e]=1` are updated; the others hold. CONTROL writes ignore `pstrb_i`.
- FLAGS and SP are read-only.
- Error conditions, each giving `pslverr_o=1`:
  - write to FLAGS or SP;
  - illegal region;
  - write to CONTROL or OPERAND while `busy_o=1`.
- An errored access changes no state.
- FSM states: IDLE, ACCESS, SP_WAIT.
  - IDLE -> ACCESS on `psel_i & !penable_i`.
  - ACCESS, non-SP access: complete, then -> IDLE.
  - ACCESS, SP read: assert `sp_rd_en_o`, then -> SP_WAIT.
  - SP_WAIT: complete with `prdata_o = sp_rd_data_i`, then -> IDLE.
- Protocol violations: `penable_i` without a prior setup, or `psel_i` dropping mid-transfer, return the FSM to IDLE with no side effects.

## Timing
- Reset values: all registers 0, all outputs 0, FSM in IDLE.
- Zero-wait accesses (all non-SP): `pready_o=1` in the first cycle with `penable_i=1`.
  - Writes commit on that edge.
  - `prdata_o` and `pslverr_o` are valid in the same cycle.
- SP read: one wait state.
  - `sp_rd_en_o` is high in the first ACCESS cycle.
  - `pready_o` is high in the second ACCESS cycle.
- `start_o` is high for the cycle after the START write commits. `busy_o` therefore rises one cycle after commit and stays high while `busy_core_i=1`.
- Simultaneous START write and `busy_core_i=1`: error, no pulse.
- FLAGS reads return `flags_i` sampled on the completing edge.
- `pready_o`, `pslverr_o`, `prdata_o`, `sp_rd_en_o` are low/zero outside their completing or strobe cycle.
- Reset mid-transfer: the FSM returns to IDLE immediately and any pending SP read is dropped.

## Configuration
- `MATMUL_APB_PSLVERR_EN` defined: error detection as above.
- Not defined:
  - `pslverr_o` is tied 0.
  - Illegal writes are silently discarded.
  - Illegal-region reads return 0.
  - Timing is unchanged.

## Structure
- `matmul_pkg` holds:
  - `DATA_WIDTH`, `BUS_WIDTH`, `ADDR_WIDTH`, `MAX_DIM`, `SP_NTARGETS`;
  - the region address constants;
  - the CONTROL bit-field localparams;
  - the FSM state enum `apb_state_e`.
- One sub-module, `matmul_operand_rf`: MAX_DIM x BUS_WIDTH register file with per-element strobes. It is instantiated twice, for A and B.

## Test plan
- Write OPERAND_A row 2 = 0x04030201 with `pstrb_i=4'b1111`, then with `pstrb_i=4'b0101` and data 0xFFFFFFFF, then read row 2 -> returns 0x04FF02FF; `pready_o` on the first ACCESS cycle.
- Write CONTROL = 0x00003F01 -> `start_o` pulses for one cycle; a CONTROL read returns 0x00003F00.
- With `busy_core_i=1`, write OPERAND_B row 0 -> `pslverr_o=1`; row 0 still reads its prior value.
- SP read, target 1, row 3, with SP returning 0xDEADBEEF -> `sp_rd_addr_o = {1,3}`; `pready_o` one cycle after `sp_rd_en_o`; `prdata_o = 0xDEADBEEF`.
- Write to FLAGS, and access region 0x14 -> `pslverr_o=1` for both with the macro defined, 0 without it; no state change in either build.
- Assert `rst_i` during the SP_WAIT cycle -> all outputs are 0 asynchronously; the next transfer completes normally.
